// File: rtl/memory_responder_pkg.sv
// Shared types and constants for the byte-serial memory responder.
// Size encodings, FSM states and the size-to-byte-count helper.
package memory_responder_pkg;

    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_WRD2 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_XFER = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        unique case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_responder_mem.sv
// Byte-wide storage: synchronous write, asynchronous read, no reset.
// Contents survive reset by design.
module mem_byte_array #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// Byte-serial memory responder: MFA/MFC handshake, wait states,
// big-endian multi-byte transfers over a byte-wide array.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int MEM_DEPTH   = memory_responder_pkg::MEM_DEPTH
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              MFA,
    input  logic              readWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       dataIn,
    input  logic [1:0]        dataSize,
    output logic [31:0]       dataOut,
    output logic              MFC
);

    localparam logic [3:0] WAIT4 = 4'(WAIT_STATES);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [3:0]        wcnt;
    logic [2:0]        bcnt;
    logic [31:0]       sh;
    logic [31:0]       wr_align;
    logic [7:0]        rdata;
    logic              we;

    // Write data is left-justified so the top byte always goes out next.
    always_comb begin
        wr_align = dataIn;
        unique case (dataSize)
            SZ_BYTE: wr_align = {dataIn[7:0], 24'h0};
            SZ_HALF: wr_align = {dataIn[15:0], 16'h0};
            default: wr_align = dataIn;
        endcase
    end

    assign we = (state == ST_XFER) && !rw_q;

    mem_byte_array #(
        .DEPTH(MEM_DEPTH),
        .AW   (ADDR_W)
    ) u_mem (
        .clk  (Clk),
        .we   (we),
        .waddr(addr_q),
        .wdata(sh[31:24]),
        .raddr(addr_q),
        .rdata(rdata)
    );

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wcnt    <= '0;
            bcnt    <= '0;
            sh      <= '0;
            dataOut <= '0;
            MFC     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    MFC <= 1'b0;
                    if (MFA) begin
                        addr_q <= address;
                        rw_q   <= readWrite;
                        bcnt   <= size_bytes(dataSize);
                        wcnt   <= WAIT4;
                        sh     <= readWrite ? 32'h0 : wr_align;
                        state  <= (WAIT4 == 4'd0) ? ST_XFER : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt <= 4'd1) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    addr_q <= addr_q + 1'b1;
                    bcnt   <= bcnt - 3'd1;
                    sh     <= {sh[23:0], rw_q ? rdata : 8'h00};
                    if (bcnt == 3'd1) begin
                        MFC   <= 1'b1;
                        state <= ST_DONE;
                        if (rw_q) begin
                            dataOut <= {sh[23:0], rdata};
                        end
                    end
                end
                ST_DONE: begin
                    if (!MFA) begin
                        MFC   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (WAIT_STATES=2 and 0).
module tb_memory_responder;

    logic        Clk;
    logic        reset;
    logic        MFA;
    logic        mfa0;
    logic        readWrite;
    logic [8:0]  address;
    logic [31:0] dataIn;
    logic [1:0]  dataSize;
    logic [31:0] dataOut;
    logic [31:0] out0;
    logic        MFC;
    logic        mfc0;

    int total = 0;
    int bad   = 0;
    int lat;

    memory_responder #(.WAIT_STATES(2)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .MFA      (MFA),
        .readWrite(readWrite),
        .address  (address),
        .dataIn   (dataIn),
        .dataSize (dataSize),
        .dataOut  (dataOut),
        .MFC      (MFC)
    );

    memory_responder #(.WAIT_STATES(0)) dut0 (
        .Clk      (Clk),
        .reset    (reset),
        .MFA      (mfa0),
        .readWrite(readWrite),
        .address  (address),
        .dataIn   (dataIn),
        .dataSize (dataSize),
        .dataOut  (out0),
        .MFC      (mfc0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut; lat = edges from accept to MFC rise.
    task automatic op(input logic rw, input logic [8:0] a,
                      input logic [31:0] d, input logic [1:0] sz,
                      input int hold, output int l);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        @(negedge Clk);
        readWrite = rw;
        address   = a;
        dataIn    = d;
        dataSize  = sz;
        MFA       = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 1) begin
                address   = ~a;
                dataIn    = 32'hDEADBEEF;
                dataSize  = ~sz;
                readWrite = ~rw;
            end
            if (MFC) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check("mfc_timeout", 32'(MFC), 32'h1);
        end
        l = n - 1;
        for (int k = 0; k < hold; k++) begin
            @(posedge Clk);
            #1;
            check("mfc_hold", 32'(MFC), 32'h1);
        end
        @(negedge Clk);
        MFA = 1'b0;
        @(posedge Clk);
        #1;
        check("mfc_clear", 32'(MFC), 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        MFA       = 1'b0;
        mfa0      = 1'b0;
        readWrite = 1'b0;
        address   = '0;
        dataIn    = '0;
        dataSize  = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_mfc", 32'(MFC), 32'h0);
        check("rst_dout", dataOut, 32'h0);
        @(negedge Clk);
        reset = 1'b1;

        op(1'b0, 9'd4, 32'h11223344, 2'b10, 0, lat);
        check("wr_word_lat", 32'(lat), 32'd6);
        check("byte4", 32'(dut.u_mem.mem[4]), 32'h11);
        check("byte7", 32'(dut.u_mem.mem[7]), 32'h44);
        check("wr_keeps_dout", dataOut, 32'h0);

        op(1'b1, 9'd4, 32'h0, 2'b10, 0, lat);
        check("rd_word_lat", 32'(lat), 32'd6);
        check("rd_word", dataOut, 32'h11223344);

        op(1'b0, 9'd511, 32'h0000BEEF, 2'b01, 0, lat);
        check("wr_half_lat", 32'(lat), 32'd4);
        op(1'b1, 9'd511, 32'h0, 2'b00, 0, lat);
        check("rd_byte_lat", 32'(lat), 32'd3);
        check("rd_511", dataOut, 32'h000000BE);
        op(1'b1, 9'd0, 32'h0, 2'b00, 0, lat);
        check("rd_0_wrap", dataOut, 32'h000000EF);

        op(1'b0, 9'd8, 32'h0, 2'b00, 0, lat);
        op(1'b0, 9'd9, 32'h0, 2'b00, 0, lat);
        op(1'b0, 9'd11, 32'h0, 2'b00, 0, lat);
        op(1'b0, 9'd10, 32'hFFFFFFA5, 2'b00, 0, lat);
        check("byte_wr_dout_held", dataOut, 32'h000000EF);
        op(1'b1, 9'd8, 32'h0, 2'b11, 0, lat);
        check("rd_size11_lat", 32'(lat), 32'd6);
        check("rd_misaligned", dataOut, 32'h0000A500);

        op(1'b1, 9'd4, 32'h0, 2'b00, 5, lat);
        check("hold_data", dataOut, 32'h00000011);
        repeat (6) @(posedge Clk);
        #1;
        check("no_second", 32'(MFC), 32'h0);

        // MFA dropped during WAIT: one-cycle MFC pulse
        begin
            int n;
            n = 0;
            @(negedge Clk);
            readWrite = 1'b1;
            address   = 9'd7;
            dataSize  = 2'b00;
            MFA       = 1'b1;
            @(negedge Clk);
            MFA = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge Clk);
                #1;
                n++;
                if (MFC) break;
            end
            check("drop_lat", 32'(n), 32'd3);
            check("drop_data", dataOut, 32'h00000044);
            @(posedge Clk);
            #1;
            check("drop_pulse", 32'(MFC), 32'h0);
        end

        op(1'b0, 9'd20, 32'h01020304, 2'b10, 0, lat);
        @(negedge Clk);
        readWrite = 1'b0;
        address   = 9'd20;
        dataIn    = 32'hCAFEF00D;
        dataSize  = 2'b10;
        MFA       = 1'b1;
        repeat (5) @(posedge Clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_mfc", 32'(MFC), 32'h0);
        check("rst_mid_dout", dataOut, 32'h0);
        MFA = 1'b0;
        @(posedge Clk);
        #1;
        check("byte20", 32'(dut.u_mem.mem[20]), 32'hCA);
        check("byte21", 32'(dut.u_mem.mem[21]), 32'hFE);
        check("byte22", 32'(dut.u_mem.mem[22]), 32'h03);
        check("byte23", 32'(dut.u_mem.mem[23]), 32'h04);
        @(negedge Clk);
        reset = 1'b1;
        op(1'b1, 9'd20, 32'h0, 2'b00, 0, lat);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_rd", dataOut, 32'h000000CA);

        // Zero wait states on the second instance
        begin
            int n;
            @(negedge Clk);
            readWrite = 1'b0;
            address   = 9'd100;
            dataIn    = 32'h0000005A;
            dataSize  = 2'b00;
            mfa0      = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(posedge Clk);
                #1;
                if (mfc0) break;
            end
            @(negedge Clk);
            mfa0 = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            readWrite = 1'b1;
            mfa0      = 1'b1;
            n = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge Clk);
                #1;
                n++;
                if (mfc0) break;
            end
            check("w0_lat", 32'(n - 1), 32'd1);
            check("w0_data", out0, 32'h0000005A);
            @(negedge Clk);
            mfa0 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
